hack_fetch: RTL and testbench

Instruction fetch unit for the Hack CPU. It consumes the program counter's `out` value and drives the PC's `inc` input. It issues in-order read requests to the instruction ROM over a valid/ready request channel and buffers returned instruction words with their addresses in a small queue. The decode stage pops that queue, and the queue is flushed when the CPU takes a jump and loads a new PC value.

---
 rtl/hack_pkg.sv | 14 +
 rtl/hack_sync_fifo.sv | 47 ++++
 rtl/hack_fetch.sv | 106 ++++++++++
 tb/tb_hack_fetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types for the Hack CPU instruction fetch path.
package hack_pkg;

    localparam int ROM_AW = 15;

    typedef logic [15:0]       word_t;
    typedef logic [ROM_AW-1:0] rom_addr_t;

    typedef struct packed {
        word_t addr;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/hack_sync_fifo.sv
// Small synchronous FIFO with clear, occupancy count and a registered head.
module hack_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch: credit-limited in-order ROM requests, tag and
// instruction queues, and discard of responses that belong to a flushed path.
module hack_fetch
    import hack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  word_t     pc_addr,
    output logic      pc_inc,
    input  logic      flush,
    output logic      rom_req_valid,
    input  logic      rom_req_ready,
    output rom_addr_t rom_req_addr,
    input  logic      rom_rsp_valid,
    input  word_t     rom_rsp_data,
    output logic      instr_valid,
    input  logic      instr_ready,
    output word_t     instr_data,
    output word_t     instr_addr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [CW-1:0] q_count;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW:0]   credit_used;
    word_t         tag_head;
    fetch_entry_t  head_entry;
    fetch_entry_t  rsp_entry;
    logic          fire;
    logic          rsp_ok;
    logic          rsp_keep;
    logic          pop;

    // Handshakes: a transfer happens in a cycle where valid && ready; valid never
    // waits on ready. ROM responses are in request order and cannot be stalled.
    assign credit_used   = {1'b0, q_count} + {1'b0, inflight};
    assign rom_req_valid = !reset && !flush && (credit_used < CREDITS);
    assign fire          = rom_req_valid && rom_req_ready;
    assign pc_inc        = fire;
    assign rom_req_addr  = pc_addr[ROM_AW-1:0];

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok   = rom_rsp_valid && (inflight != '0);
    assign rsp_keep = rsp_ok && !flush && (discard == '0);

    assign instr_valid = (q_count != '0) && !flush;
    assign pop         = instr_valid && instr_ready;

    assign rsp_entry.addr  = tag_head;
    assign rsp_entry.instr = rom_rsp_data;
    assign instr_data      = head_entry.instr;
    assign instr_addr      = head_entry.addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CW'(fire) - CW'(rsp_ok);
            // Requests are never issued in a flush cycle, so only a response can shrink the count.
            if (flush) begin
                discard <= inflight - CW'(rsp_ok);
            end else if (rsp_ok && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
        end
    end

    hack_sync_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (fire),
        .push_data (pc_addr),
        .pop       (rsp_ok),
        .head      (tag_head),
        .count     (tag_count)
    );

    hack_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (rsp_keep),
        .push_data (rsp_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (q_count)
    );

    // Every outstanding request owns exactly one tag.
    a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (reset) tag_count == inflight);

endmodule

// File: tb/tb_hack_fetch.sv
// Randomized and directed bench for hack_fetch against a queue-based reference model.
module tb_hack_fetch;
    import hack_pkg::*;

    localparam int DEPTH = 2;

    logic      clk = 1'b0;
    logic      reset;
    word_t     pc_addr;
    logic      pc_inc;
    logic      flush;
    logic      rom_req_valid;
    logic      rom_req_ready;
    rom_addr_t rom_req_addr;
    logic      rom_rsp_valid;
    word_t     rom_rsp_data;
    logic      instr_valid;
    logic      instr_ready;
    word_t     instr_data;
    word_t     instr_addr;

    hack_fetch #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_addr       (pc_addr),
        .pc_inc        (pc_inc),
        .flush         (flush),
        .rom_req_valid (rom_req_valid),
        .rom_req_ready (rom_req_ready),
        .rom_req_addr  (rom_req_addr),
        .rom_rsp_valid (rom_rsp_valid),
        .rom_rsp_data  (rom_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr)
    );

    // clock / reset / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] due;
        rom_addr_t   addr;
    } rom_t;

    logic [31:0] exp_q[$];   // decoded entries {addr, data}
    logic [16:0] pend_q[$];  // outstanding requests {drop, addr}
    rom_t        rom_q[$];

    int    cyc = 0;
    word_t pc = '0;
    int    k_ready_pct = 100;
    int    k_iready_pct = 100;
    int    k_flush_pm = 0;
    int    k_lat_min = 1;
    int    k_lat_max = 1;
    int    k_spur_pct = 0;
    logic  force_flush = 1'b0;
    word_t flush_target = '0;
    int    fire_cnt = 0;
    int    first_fire = -1;
    int    first_valid = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic word_t rom_word(input rom_addr_t a);
        return {1'b0, a} ^ {a[6:0], 9'h000};
    endfunction

    // one clock cycle: drive, check outputs against the model, advance the model
    task automatic step();
        logic        exp_rv;
        logic        exp_fire;
        logic        exp_iv;
        logic        rsp_real;
        logic        spur;
        logic [16:0] p;
        logic [31:0] due;
        int          drops;

        flush = !reset && (force_flush || ($urandom_range(999) < k_flush_pm));
        if (!force_flush) flush_target = 16'($urandom);
        force_flush = 1'b0;
        rsp_real = !reset && (rom_q.size() > 0) && (rom_q[0].due <= cyc);
        spur = !reset && !rsp_real && (rom_q.size() == 0) && (pend_q.size() == 0)
               && ($urandom_range(99) < k_spur_pct);
        rom_rsp_valid = rsp_real || spur;
        rom_rsp_data  = rsp_real ? rom_word(rom_q[0].addr) : 16'($urandom);
        rom_req_ready = $urandom_range(99) < k_ready_pct;
        instr_ready   = $urandom_range(99) < k_iready_pct;
        pc_addr       = pc;
        #1;

        exp_rv   = !reset && !flush && ((exp_q.size() + pend_q.size()) < DEPTH);
        exp_fire = exp_rv && rom_req_ready;
        exp_iv   = !flush && (exp_q.size() > 0);
        drops = 0;
        foreach (pend_q[i]) if (pend_q[i][16]) drops++;

        check("rom_req_valid", 32'(rom_req_valid), 32'(exp_rv));
        check("pc_inc", 32'(pc_inc), 32'(exp_fire));
        check("rom_req_addr", 32'(rom_req_addr), 32'(pc[14:0]));
        check("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("instr_addr", 32'(instr_addr), 32'(exp_q[0][31:16]));
            check("instr_data", 32'(instr_data), 32'(exp_q[0][15:0]));
        end
        check("q_count", 32'(dut.q_count), exp_q.size());
        check("inflight", 32'(dut.inflight), pend_q.size());
        check("discard", 32'(dut.discard), drops);

        if (pc_inc) fire_cnt++;
        if (pc_inc && first_fire < 0) first_fire = cyc;
        if (instr_valid && first_valid < 0) first_valid = cyc;

        if (reset) begin
            exp_q.delete();
            pend_q.delete();
            rom_q.delete();
        end else begin
            if (flush) exp_q.delete();
            else if (exp_iv && instr_ready) void'(exp_q.pop_front());
            if (rom_rsp_valid && (pend_q.size() > 0)) begin
                p = pend_q.pop_front();
                if (!p[16] && !flush) exp_q.push_back({p[15:0], rom_rsp_data});
            end
            if (flush) foreach (pend_q[i]) pend_q[i][16] = 1'b1;
            if (exp_fire) pend_q.push_back({1'b0, pc});
            if (flush) pc = flush_target;
            else if (exp_fire) pc = pc + 16'd1;

            if (rsp_real) void'(rom_q.pop_front());
            if (rom_req_valid && rom_req_ready) begin
                due = 32'(cyc + $urandom_range(k_lat_max, k_lat_min));
                if ((rom_q.size() > 0) && (due <= rom_q[rom_q.size()-1].due))
                    due = rom_q[rom_q.size()-1].due + 32'd1;
                rom_q.push_back('{due: due, addr: rom_req_addr});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
        fire_cnt    = 0;
        first_fire  = -1;
        first_valid = -1;
    endtask

    task automatic set_directed(input int lat, input int iready_pct);
        k_ready_pct  = 100;
        k_iready_pct = iready_pct;
        k_flush_pm   = 0;
        k_lat_min    = lat;
        k_lat_max    = lat;
        k_spur_pct   = 0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        word_t saved_addr;
        reset = 1'b1;
        flush = 1'b0;
        pc_addr = '0;
        rom_req_ready = 1'b0;
        rom_rsp_valid = 1'b0;
        rom_rsp_data = '0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        set_directed(1, 100);
        do_reset(3);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_q_count", 32'(dut.q_count), 32'd0);
        check("rst_inflight", 32'(dut.inflight), 32'd0);
        check("rst_discard", 32'(dut.discard), 32'd0);

        // streaming, L=1
        pc = 16'h0000;
        run(12);
        check("stream_latency", 32'(first_valid - first_fire), 32'd2);
        check("stream_fires_nonzero", 32'(fire_cnt >= 5), 32'd1);

        // backpressure
        set_directed(1, 0);
        do_reset(1);
        pc = 16'h0000;
        run(8);
        check("bp_fires", 32'(fire_cnt), 32'd2);
        check("bp_req_valid", 32'(rom_req_valid), 32'd0);
        check("bp_head_addr", 32'(instr_addr), 32'h0000);
        check("bp_head_data", 32'(instr_data), 32'(rom_word(15'h0000)));
        k_iready_pct = 100;
        run(6);

        // flush with two requests in flight
        set_directed(3, 100);
        do_reset(1);
        pc = 16'h0000;
        run(2);
        force_flush  = 1'b1;
        flush_target = 16'h0100;
        run(1);
        check("fl2_discard", 32'(dut.discard), 32'd2);
        wait_valid("fl2_valid", 20);
        check("fl2_addr", 32'(instr_addr), 32'h0100);
        check("fl2_data", 32'(instr_data), 32'(rom_word(15'h0100)));

        // flush in the same cycle as a response
        set_directed(2, 100);
        do_reset(1);
        pc = 16'h0000;
        run(2);
        force_flush  = 1'b1;
        flush_target = 16'h0200;
        run(1);
        check("flrsp_discard", 32'(dut.discard), 32'd1);
        check("flrsp_inflight", 32'(dut.inflight), 32'd1);
        run(1);
        check("flrsp_no_stale", 32'(instr_valid), 32'd0);
        run(8);

        // ROM stall
        k_ready_pct = 0;
        fire_cnt = 0;
        run(5);
        check("stall_fires", 32'(fire_cnt), 32'd0);
        k_ready_pct = 100;
        run(3);
        check("stall_resume", 32'(fire_cnt > 0), 32'd1);

        // reset mid-stream with one queued and one in flight
        set_directed(3, 0);
        do_reset(1);
        pc = 16'h0000;
        run(4);
        check("mid_q_count", 32'(dut.q_count), 32'd1);
        check("mid_inflight", 32'(dut.inflight), 32'd1);
        do_reset(1);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_q_count", 32'(dut.q_count), 32'd0);
        check("mid_rst_inflight", 32'(dut.inflight), 32'd0);
        check("mid_rst_discard", 32'(dut.discard), 32'd0);
        set_directed(1, 100);
        pc = 16'h8003;
        pc_addr = pc;
        #1;
        check("mid_rom_addr", 32'(rom_req_addr), 32'h0003);
        wait_valid("mid_valid", 10);
        check("mid_instr_addr", 32'(instr_addr), 32'h8003);
        check("mid_instr_data", 32'(instr_data), 32'(rom_word(15'h0003)));

        // randomized traffic
        for (int b = 0; b < 20; b++) begin
            k_ready_pct  = $urandom_range(100, 30);
            k_iready_pct = $urandom_range(100, 20);
            k_flush_pm   = $urandom_range(60, 0);
            k_lat_min    = $urandom_range(3, 1);
            k_lat_max    = $urandom_range(6, k_lat_min);
            k_spur_pct   = $urandom_range(10, 0);
            if (b % 7 == 3) do_reset(2);
            run(100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
